// File: rtl/pipe_ctrl.sv
// Central pipeline controller: arbitrates stall, branch and trap requests into per-stage
// stall/flush vectors, sequences deferred trap entry, and runs a MEM bus watchdog plus counters.
module pipe_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    input  logic        trap_req_i,
    input  logic [31:0] trap_addr_i,
    output logic [5:0]  stall_o,
    output logic [2:0]  flush_o,
    output logic        pc_set_o,
    output logic [31:0] new_pc_o,
    output logic        trap_ack_o,
    output logic        bus_timeout_o,
    output logic        bus_err_o,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    typedef enum logic {
        IDLE      = 1'b0,
        TRAP_PEND = 1'b1
    } state_e;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT_CYC);

    state_e      state_q, state_d;
    logic [31:0] trap_addr_q, trap_addr_d;
    logic [7:0]  wdt_cnt_q, wdt_cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        bus_timeout_q, bus_timeout_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic        blocked;
    logic        trap_eff;
    logic        trap_take;
    logic [31:0] trap_tgt;

    // A trap cannot be taken while MEM or EX would have to abandon an in-flight operation.
    assign blocked   = stallreq_mem | stallreq_ex;
    assign trap_eff  = (state_q == TRAP_PEND) | trap_req_i;
    assign trap_tgt  = (state_q == TRAP_PEND) ? trap_addr_q : trap_addr_i;
    assign trap_take = trap_eff & ~blocked;

    always_comb begin
        // NOTE: every output gets a default first so no path through the priority chain infers a latch.
        stall_o    = 6'b000000;
        flush_o    = 3'b000;
        pc_set_o   = 1'b0;
        new_pc_o   = 32'h0;
        trap_ack_o = 1'b0;
        if (trap_take) begin
            flush_o    = 3'b111;
            pc_set_o   = 1'b1;
            new_pc_o   = trap_tgt;
            trap_ack_o = 1'b1;
        end else if (stallreq_mem) begin
            stall_o = 6'b011111;
        end else if (stallreq_ex) begin
            stall_o = 6'b001111;
        end else if (branch_flag_i) begin
            flush_o  = 3'b011;
            pc_set_o = 1'b1;
            new_pc_o = branch_addr_i;
        end else if (stallreq_id) begin
            stall_o = 6'b000111;
        end else if (stallreq_if) begin
            stall_o = 6'b000011;
        end
    end

    always_comb begin
        state_d     = state_q;
        trap_addr_d = trap_addr_q;
        case (state_q)
            IDLE: begin
                if (trap_req_i && blocked) begin
                    state_d     = TRAP_PEND;
                    trap_addr_d = trap_addr_i;
                end
            end
            TRAP_PEND: begin
                // Later requests are dropped here: the first trap owns the vector.
                if (!blocked) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wdt_cnt_d     = 8'd0;
        bus_timeout_d = 1'b0;
        if (stallreq_mem) begin
            wdt_cnt_d     = (wdt_cnt_q == TIMEOUT_W) ? wdt_cnt_q : wdt_cnt_q + 8'd1;
            bus_timeout_d = (wdt_cnt_q == TIMEOUT_W - 8'd1);
        end
        bus_err_d   = bus_err_q | bus_timeout_d;
        stall_cnt_d = stall_cnt_q + {31'b0, |stall_o};
        flush_cnt_d = flush_cnt_q + {15'b0, |flush_o};
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
        if (!rst) begin
            state_q       <= IDLE;
            trap_addr_q   <= 32'h0;
            wdt_cnt_q     <= 8'd0;
            bus_err_q     <= 1'b0;
            bus_timeout_q <= 1'b0;
            stall_cnt_q   <= 32'h0;
            flush_cnt_q   <= 16'h0;
        end else begin
            state_q       <= state_d;
            trap_addr_q   <= trap_addr_d;
            wdt_cnt_q     <= wdt_cnt_d;
            bus_err_q     <= bus_err_d;
            bus_timeout_q <= bus_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign bus_timeout_o = bus_timeout_q;
    assign bus_err_o     = bus_err_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then randomized traffic,
// all compared every cycle against a queue-based behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        trap_req_i = 1'b0;
    logic [31:0] trap_addr_i = 32'h0;
    logic [5:0]  stall_o;
    logic [2:0]  flush_o;
    logic        pc_set_o, trap_ack_o, bus_timeout_o, bus_err_o;
    logic [31:0] new_pc_o, stall_cnt_o;
    logic [15:0] flush_cnt_o;

    pipe_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i),
        .trap_req_i(trap_req_i), .trap_addr_i(trap_addr_i),
        .stall_o(stall_o), .flush_o(flush_o), .pc_set_o(pc_set_o), .new_pc_o(new_pc_o),
        .trap_ack_o(trap_ack_o), .bus_timeout_o(bus_timeout_o), .bus_err_o(bus_err_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a pending trap is a queue of at most one vector; the watchdog is a run length.
    logic [31:0] pend_q[$];
    int          m_run = 0;
    bit          m_to = 0, m_err = 0;
    logic [31:0] m_stall_cnt = 0;
    logic [15:0] m_flush_cnt = 0;

    typedef struct packed {
        logic [5:0]  stall;
        logic [2:0]  flush;
        logic        pc_set;
        logic [31:0] pc;
        logic        ack;
    } exp_t;

    function automatic exp_t expect_now();
        exp_t e = '0;
        bit   have_trap = (pend_q.size() > 0) || trap_req_i;
        if (have_trap && !stallreq_mem && !stallreq_ex) begin
            e.flush = 3'b111; e.pc_set = 1'b1; e.ack = 1'b1;
            e.pc    = (pend_q.size() > 0) ? pend_q[0] : trap_addr_i;
        end else if (stallreq_mem)  e.stall = 6'b011111;
        else if (stallreq_ex)       e.stall = 6'b001111;
        else if (branch_flag_i) begin
            e.flush = 3'b011; e.pc_set = 1'b1; e.pc = branch_addr_i;
        end
        else if (stallreq_id)       e.stall = 6'b000111;
        else if (stallreq_if)       e.stall = 6'b000011;
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = expect_now();
        if (!rst) begin
            pend_q.delete();
            m_run = 0; m_to = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (e.ack) void'(pend_q.pop_front());
            else if (trap_req_i && pend_q.size() == 0 && (stallreq_mem || stallreq_ex))
                pend_q.push_back(trap_addr_i);
            if (stallreq_mem) begin
                m_to  = (m_run + 1 == int'(TO));
                m_run = (m_run + 1 > int'(TO)) ? int'(TO) : m_run + 1;
            end else begin
                m_run = 0; m_to = 0;
            end
            m_err = m_err | m_to;
            if (e.stall != 0) m_stall_cnt = m_stall_cnt + 1;
            if (e.flush != 0) m_flush_cnt = m_flush_cnt + 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (chk_en) begin
            e = expect_now();
            check("stall_o",       32'(stall_o),       32'(e.stall));
            check("flush_o",       32'(flush_o),       32'(e.flush));
            check("pc_set_o",      32'(pc_set_o),      32'(e.pc_set));
            check("new_pc_o",      new_pc_o,           e.pc);
            check("trap_ack_o",    32'(trap_ack_o),    32'(e.ack));
            check("bus_timeout_o", 32'(bus_timeout_o), 32'(m_to));
            check("bus_err_o",     32'(bus_err_o),     32'(m_err));
            check("stall_cnt_o",   stall_cnt_o,        m_stall_cnt);
            check("flush_cnt_o",   32'(flush_cnt_o),   32'(m_flush_cnt));
        end
    end

    // req = {mem, ex, id, if}
    task automatic step(input logic r, input logic [3:0] req, input logic br, input logic [31:0] ba,
                        input logic tr, input logic [31:0] ta);
        @(negedge clk);
        rst = r;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        branch_flag_i = br; branch_addr_i = ba;
        trap_req_i = tr; trap_addr_i = ta;
        #3;
    endtask

    initial begin
        int mem_left = 0;
        step(1'b0, 4'b0000, 1'b0, 0, 1'b0, 0);
        step(1'b0, 4'b0000, 1'b0, 0, 1'b0, 0);
        chk_en = 1'b1;
        step(1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);
        check("lit_reset_stall_cnt", stall_cnt_o, 32'h0);
        check("lit_reset_flush_cnt", 32'(flush_cnt_o), 32'h0);
        check("lit_reset_bus_err", 32'(bus_err_o), 32'h0);

        step(1'b1, 4'b0010, 1'b0, 0, 1'b0, 0);
        check("lit_id_stall", 32'(stall_o), 32'h07);
        check("lit_id_flush", 32'(flush_o), 32'h0);

        step(1'b1, 4'b0001, 1'b1, 32'h0000_0100, 1'b0, 0);
        check("lit_id_stall_cnt", stall_cnt_o, 32'd1);
        check("lit_br_pc_set", 32'(pc_set_o), 32'd1);
        check("lit_br_new_pc", new_pc_o, 32'h0000_0100);
        check("lit_br_flush", 32'(flush_o), 32'h3);
        check("lit_br_stall", 32'(stall_o), 32'h0);
        step(1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);
        check("lit_br_flush_cnt", 32'(flush_cnt_o), 32'd1);

        step(1'b1, 4'b1000, 1'b0, 0, 1'b1, 32'h0000_0040);
        check("lit_trap_c1_stall", 32'(stall_o), 32'h1F);
        check("lit_trap_c1_ack", 32'(trap_ack_o), 32'h0);
        step(1'b1, 4'b1000, 1'b0, 0, 1'b1, 32'h0000_0080);
        check("lit_trap_c2_ack", 32'(trap_ack_o), 32'h0);
        step(1'b1, 4'b1000, 1'b0, 0, 1'b0, 0);
        check("lit_trap_c3_stall", 32'(stall_o), 32'h1F);
        step(1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);
        check("lit_trap_c4_ack", 32'(trap_ack_o), 32'd1);
        check("lit_trap_c4_pc", new_pc_o, 32'h0000_0040);
        check("lit_trap_c4_flush", 32'(flush_o), 32'h7);
        step(1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);
        check("lit_trap_c5_ack", 32'(trap_ack_o), 32'h0);

        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 4'b1000, 1'b0, 0, 1'b0, 0);
            check("lit_wdt_timeout", 32'(bus_timeout_o), (k == 5) ? 32'd1 : 32'd0);
        end
        step(1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);
        check("lit_wdt_timeout_end", 32'(bus_timeout_o), 32'h0);
        check("lit_wdt_err_sticky", 32'(bus_err_o), 32'd1);

        step(1'b1, 4'b1000, 1'b0, 0, 1'b1, 32'h0000_0200);
        step(1'b0, 4'b1000, 1'b0, 0, 1'b0, 0);
        step(1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);
        check("lit_rst_pend_ack", 32'(trap_ack_o), 32'h0);
        check("lit_rst_pend_stall_cnt", stall_cnt_o, 32'h0);
        check("lit_rst_pend_flush_cnt", 32'(flush_cnt_o), 32'h0);
        check("lit_rst_pend_err", 32'(bus_err_o), 32'h0);

        @(posedge clk); #1;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_stall_cnt = 32'hFFFF_FFFF;
        step(1'b1, 4'b0010, 1'b0, 0, 1'b0, 0);
        step(1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);
        check("lit_stall_cnt_wrap", stall_cnt_o, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            logic       r, mem;
            logic [3:0] req;
            r = ($urandom_range(0, 99) != 0);
            if (mem_left > 0) begin
                mem = 1'b1; mem_left--;
            end else begin
                mem = 1'b0;
                if ($urandom_range(0, 9) == 0) mem_left = $urandom_range(1, 7);
            end
            req = {mem, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0)};
            step(r, req, ($urandom_range(0, 4) == 0), $urandom,
                 ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the bittyCore five-stage RISC-V pipeline. It arbitrates stall requests from IF/ID/EX/MEM and branch redirects from EX. It also sequences trap entry, including trap requests that arrive while the pipeline is stalled. Its stall and flush vectors drive the `pc_reg`, `if_id`, `id_ex`, `ex_mem` and `mem_wb` pipeline registers. It also provides a MEM bus-stall watchdog and two performance counters.

## Interface
- TIMEOUT_CYC, 200: consecutive MEM-stall cycles that trigger a bus timeout; 1..255.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- stallreq_if  in  1  instruction fetch bus wait.
- stallreq_id  in  1  load-use hazard.
- stallreq_ex  in  1  multi-cycle EX operation busy.
- stallreq_mem  in  1  data bus wait.
- branch_flag_i  in  1  EX resolves a taken branch or jump.
- branch_addr_i  in  32  branch target.
- trap_req_i  in  1  single-cycle trap/interrupt request pulse.
- trap_addr_i  in  32  trap vector, valid with trap_req_i.
- stall_o  out  6  hold per stage: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 reserved (always 0).
- flush_o  out  3  bubble insert: bit0 if_id, bit1 id_ex, bit2 ex_mem.
- pc_set_o  out  1  load new_pc_o into pc this cycle.
- new_pc_o  out  32  redirect target.
- trap_ack_o  out  1  trap taken this cycle.
- bus_timeout_o  out  1  one-cycle pulse on watchdog expiry.
- bus_err_o  out  1  sticky watchdog error.
- stall_cnt_o  out  32  cycles with stall_o != 0, wrap-around.
- flush_cnt_o  out  16  flush events (flush_o != 0), wrap-around.

## Operation
- State machine: IDLE, TRAP_PEND. Registers: trap_addr_q (32), wdt_cnt (8), bus_err, bus_timeout, both counters.
- A trap is effective when trap_req_i=1 in IDLE, or whenever the state is TRAP_PEND. The target is trap_addr_i in IDLE and trap_addr_q in TRAP_PEND.
- A trap is blocked when stallreq_mem or stallreq_ex is 1.
- Combinational output priority, highest first:
  1. Effective trap, not blocked: stall_o=0, flush_o=3'b111, pc_set_o=1, new_pc_o=target, trap_ack_o=1.
  2. stallreq_mem: stall_o=6'b011111.
  3. stallreq_ex: stall_o=6'b001111.
  4. branch_flag_i: flush_o=3'b011, pc_set_o=1, new_pc_o=branch_addr_i. stallreq_id and stallreq_if are ignored.
  5. stallreq_id: stall_o=6'b000111.
  6. stallreq_if: stall_o=6'b000011.
  7. None of the above: all outputs 0.
- Default values: stall_o, flush_o, pc_set_o and trap_ack_o are 0 unless set by the active priority level. new_pc_o is 0 unless pc_set_o=1.
- FSM transitions:
  - IDLE to TRAP_PEND when trap_req_i=1 and blocked; trap_addr_q <= trap_addr_i.
  - TRAP_PEND to IDLE when not blocked; the trap is taken that cycle.
  - In TRAP_PEND, a new trap_req_i is dropped. The first trap wins.
- Watchdog:
  - wdt_cnt increments each cycle stallreq_mem=1 and clears when stallreq_mem=0.
  - It saturates at TIMEOUT_CYC.
  - On the cycle where wdt_cnt reaches TIMEOUT_CYC, bus_timeout is set to 1 for one cycle and bus_err is set.
  - bus_err clears only on reset. The stall itself is not released.
- stall_cnt_o increments by 1 in every cycle with stall_o != 0. flush_cnt_o increments by 1 in every cycle with flush_o != 0.

## Timing
- Reset, rst=0 at a clock edge: state=IDLE and all registers 0.
  - stall_o, flush_o, pc_set_o and trap_ack_o are combinational from inputs and state. They still follow their inputs during reset.
  - The pending trap is discarded if reset occurs mid-pending.
- Zero-latency decisions: stall, flush, redirect and trap acknowledge are all valid in the same cycle as the request.
- A pending trap is taken in the first cycle where stallreq_mem=0 and stallreq_ex=0, with zero extra delay.
- bus_timeout_o rises on the clock edge where wdt_cnt goes from TIMEOUT_CYC-1 to TIMEOUT_CYC. This is the edge that ends the TIMEOUT_CYC-th consecutive stall cycle. bus_timeout_o is high for the following cycle only.
- Counters update one edge after the qualifying cycle and wrap from all-ones to 0.
- Simultaneous events:
  - trap_req_i with branch_flag_i, unblocked: the trap wins and the branch is discarded.
  - Trap with stallreq_id: the trap wins.
  - Branch with stallreq_mem: the stall wins. EX is held, so it re-presents the branch.

## Test plan
- Reset, then stallreq_id=1 for 1 cycle → stall_o=6'b000111, flush_o=0; stall_cnt_o=1 after the edge.
- branch_flag_i=1, branch_addr_i=0x0000_0100, stallreq_if=1 → pc_set_o=1, new_pc_o=0x100, flush_o=3'b011, stall_o=0; flush_cnt_o=1 next cycle.
- stallreq_mem=1 for 3 cycles, with trap_req_i pulsed in cycle 1 (addr 0x0000_0040) → stall_o=6'b011111 for 3 cycles and no ack. In cycle 4 with stall low: trap_ack_o=1, new_pc_o=0x40, flush_o=3'b111. A second trap pulse in cycle 2 is ignored.
- TIMEOUT_CYC=4, stallreq_mem held 6 cycles → bus_timeout_o high exactly 1 cycle, after the 4th stall cycle; bus_err_o stays 1 after stall drops, until rst=0.
- Pending trap, then rst=0 for 1 edge, then stalls drop → no trap_ack_o, state IDLE, all counters 0.
- Preload stall_cnt_o to 0xFFFF_FFFF (force) and stall 1 cycle → stall_cnt_o=0.
